// File: rtl/pc_gen_if.sv
// Fetch-PC generator bus: D-stage control op and M-stage redirects in, F-stage PC and status out.
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall_i;
  logic [2:0]       br_sel_i;
  logic [31:0]      instr_d_i;
  logic [WIDTH-1:0] pc_d_i;
  logic [WIDTH-1:0] rs_val_i;
  logic [WIDTH-1:0] rt_val_i;
  logic             exc_req_i;
  logic             eret_req_i;
  logic [WIDTH-1:0] epc_i;
  logic [WIDTH-1:0] pc_f_o;
  logic             bd_f_o;
  logic             adel_f_o;
  logic             taken_d_o;

  // Pipeline side: drives control and operands, observes the fetch PC.
  modport master (
    output stall_i, br_sel_i, instr_d_i, pc_d_i, rs_val_i, rt_val_i,
           exc_req_i, eret_req_i, epc_i,
    input  pc_f_o, bd_f_o, adel_f_o, taken_d_o
  );

  // PC generator side.
  modport slave (
    input  stall_i, br_sel_i, instr_d_i, pc_d_i, rs_val_i, rt_val_i,
           exc_req_i, eret_req_i, epc_i,
    output pc_f_o, bd_f_o, adel_f_o, taken_d_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-PC generator: holds the F-stage PC, resolves D-stage branches/jumps
// (delayed-branch semantics) and applies M-stage exception/eret redirects.
module pc_gen #(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(32'h0000_3000),
  parameter int unsigned     IMEM_BYTES = 16384
) (
  input logic       clk,
  input logic       reset,
  pc_gen_if.slave   bus
);

  localparam int unsigned EXT_W = WIDTH - 18;
  localparam logic [WIDTH:0] WIN_LO = (WIDTH+1)'(IMEM_BASE);
  localparam logic [WIDTH:0] WIN_HI = WIN_LO + (WIDTH+1)'(IMEM_BYTES);

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_BLEZ = 3'd3;
  localparam logic [2:0] OP_BGTZ = 3'd4;
  localparam logic [2:0] OP_BLTZ = 3'd5;
  localparam logic [2:0] OP_J    = 3'd6;
  localparam logic [2:0] OP_JR   = 3'd7;

  logic [WIDTH-1:0] pc_q;
  logic             bd_q;
  logic             adel_q;

  logic [WIDTH-1:0] pc_nxt;
  logic             bd_nxt;
  logic             adel_nxt;

  logic [WIDTH-1:0] link;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] target;
  logic             taken;
  logic             rs_zero;
  logic             rs_neg;
  logic             unused_instr;

  assign unused_instr = ^bus.instr_d_i[31:26];

  // Candidate control-transfer targets relative to the D-stage PC.
  assign link   = bus.pc_d_i + WIDTH'(4);
  assign br_off = {{EXT_W{bus.instr_d_i[15]}}, bus.instr_d_i[15:0], 2'b00};
  assign br_tgt = link + br_off;
  assign j_tgt  = {link[WIDTH-1:28], bus.instr_d_i[25:0], 2'b00};

  assign rs_zero = (bus.rs_val_i == '0);
  assign rs_neg  = bus.rs_val_i[WIDTH-1];

  // Branch condition evaluation and target select for the D-stage op.
  always_comb begin
    taken  = 1'b0;
    target = br_tgt;
    case (bus.br_sel_i)
      OP_SEQ:  taken = 1'b0;
      OP_BEQ:  taken = (bus.rs_val_i == bus.rt_val_i);
      OP_BNE:  taken = (bus.rs_val_i != bus.rt_val_i);
      OP_BLEZ: taken = rs_neg || rs_zero;
      OP_BGTZ: taken = !rs_neg && !rs_zero;
      OP_BLTZ: taken = rs_neg;
      OP_J: begin
        taken  = 1'b1;
        target = j_tgt;
      end
      OP_JR: begin
        taken  = 1'b1;
        target = bus.rs_val_i;
      end
      default: taken = 1'b0;
    endcase
  end

  assign bus.taken_d_o = taken;

  // Next fetch PC by priority: exc, eret, stall hold, taken target, sequential.
  always_comb begin
    pc_nxt   = pc_q;
    bd_nxt   = bd_q;
    adel_nxt = adel_q;
    if (bus.exc_req_i) begin
      pc_nxt = EXC_VECTOR;
      bd_nxt = 1'b0;
    end else if (bus.eret_req_i) begin
      pc_nxt = bus.epc_i;
      bd_nxt = 1'b0;
    end else if (!bus.stall_i) begin
      pc_nxt = taken ? target : (pc_q + WIDTH'(4));
      bd_nxt = (bus.br_sel_i != OP_SEQ);
    end
    if (bus.exc_req_i || bus.eret_req_i || !bus.stall_i) begin
      adel_nxt = (pc_nxt[1:0] != 2'b00) ||
                 ({1'b0, pc_nxt} < WIN_LO) ||
                 ({1'b0, pc_nxt} >= WIN_HI);
    end
  end

  // F-stage PC and per-fetch status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      bd_q   <= 1'b0;
      adel_q <= 1'b0;
    end else begin
      pc_q   <= pc_nxt;
      bd_q   <= bd_nxt;
      adel_q <= adel_nxt;
    end
  end

  assign bus.pc_f_o   = pc_q;
  assign bus.bd_f_o   = bd_q;
  assign bus.adel_f_o = adel_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed test-plan sequence plus randomized traffic,
// all checked against a behavioural model of the fetch-PC rules.
module tb_pc_gen;

  localparam longint BASE  = 64'h3000;
  localparam longint BYTES = 64'd16384;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_adel;

  pc_gen_if #(.WIDTH(32)) bus ();

  pc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: does the D-stage op transfer control?
  function automatic logic m_taken(input logic [2:0] sel, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = int'(rs);
    case (sel)
      3'd1:    return rs == rt;
      3'd2:    return rs != rt;
      3'd3:    return s <= 0;
      3'd4:    return s > 0;
      3'd5:    return s < 0;
      3'd6,
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model: destination of a taken op, computed with wide integer arithmetic.
  function automatic logic [31:0] m_target(input logic [2:0] sel, input logic [31:0] instr,
                                           input logic [31:0] pcd, input logic [31:0] rs);
    longint t;
    logic [15:0] imm;
    logic [25:0] idx;
    imm = instr[15:0];
    idx = instr[25:0];
    if (sel == 3'd7) return rs;
    if (sel == 3'd6) return ((pcd + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
    t = longint'(pcd) + 4 + 4 * longint'($signed(imm));
    return 32'(t);
  endfunction

  function automatic logic m_bad(input logic [31:0] pc);
    longint p;
    p = longint'({32'h0, pc});
    return (p % 4 != 0) || (p < BASE) || (p >= BASE + BYTES);
  endfunction

  task automatic model_update();
    logic [31:0] npc;
    if (!reset) begin
      m_pc = 32'h3000; m_bd = 1'b0; m_adel = 1'b0;
    end else if (bus.exc_req_i || bus.eret_req_i) begin
      m_pc   = bus.exc_req_i ? 32'h4180 : bus.epc_i;
      m_bd   = 1'b0;
      m_adel = m_bad(m_pc);
    end else if (!bus.stall_i) begin
      if (m_taken(bus.br_sel_i, bus.rs_val_i, bus.rt_val_i))
        npc = m_target(bus.br_sel_i, bus.instr_d_i, bus.pc_d_i, bus.rs_val_i);
      else
        npc = m_pc + 32'd4;
      m_pc   = npc;
      m_bd   = (bus.br_sel_i != 3'd0);
      m_adel = m_bad(npc);
    end
  endtask

  // One cycle: check combinational taken, clock, then check registered outputs.
  task automatic tick();
    #1;
    chk("taken_d", 32'(bus.taken_d_o),
        32'(m_taken(bus.br_sel_i, bus.rs_val_i, bus.rt_val_i)));
    @(posedge clk);
    model_update();
    #1;
    chk("pc_f", bus.pc_f_o, m_pc);
    chk("bd_f", 32'(bus.bd_f_o), 32'(m_bd));
    chk("adel_f", 32'(bus.adel_f_o), 32'(m_adel));
  endtask

  task automatic idle();
    bus.stall_i    = 1'b0;
    bus.br_sel_i   = 3'd0;
    bus.instr_d_i  = '0;
    bus.pc_d_i     = '0;
    bus.rs_val_i   = '0;
    bus.rt_val_i   = '0;
    bus.exc_req_i  = 1'b0;
    bus.eret_req_i = 1'b0;
    bus.epc_i      = '0;
  endtask

  task automatic op(input logic [2:0] sel, input logic [31:0] instr, input logic [31:0] pcd,
                    input logic [31:0] rs, input logic [31:0] rt);
    idle();
    bus.br_sel_i  = sel;
    bus.instr_d_i = instr;
    bus.pc_d_i    = pcd;
    bus.rs_val_i  = rs;
    bus.rt_val_i  = rt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_pc = '0; m_bd = 1'b0; m_adel = 1'b0;
    reset = 1'b0;
    idle();

    // Reset and free-run.
    tick();
    tick();
    chk("reset_pc", bus.pc_f_o, 32'h3000);
    chk("reset_bd", 32'(bus.bd_f_o), 32'd0);
    reset = 1'b1;
    tick(); chk("run1", bus.pc_f_o, 32'h3004);
    tick(); chk("run2", bus.pc_f_o, 32'h3008);
    tick(); chk("run3", bus.pc_f_o, 32'h300C);
    chk("run_adel", 32'(bus.adel_f_o), 32'd0);

    // beq taken backwards, then bne not taken.
    op(3'd1, 32'h0000_FFFE, 32'h3004, 32'd5, 32'd5);
    #1 chk("beq_taken", 32'(bus.taken_d_o), 32'd1);
    tick(); chk("beq_pc", bus.pc_f_o, 32'h3000); chk("beq_bd", 32'(bus.bd_f_o), 32'd1);
    op(3'd2, 32'h0000_0010, 32'h3008, 32'd7, 32'd7);
    #1 chk("bne_taken", 32'(bus.taken_d_o), 32'd0);
    tick(); chk("bne_pc", bus.pc_f_o, 32'h3004); chk("bne_bd", 32'(bus.bd_f_o), 32'd1);

    // bltz sign handling, then j.
    op(3'd5, 32'h0000_0004, 32'h3000, 32'h8000_0000, 32'd0);
    #1 chk("bltz_neg", 32'(bus.taken_d_o), 32'd1);
    tick(); chk("bltz_pc", bus.pc_f_o, 32'h3014);
    op(3'd5, 32'h0000_0004, 32'h3010, 32'd0, 32'd0);
    #1 chk("bltz_zero", 32'(bus.taken_d_o), 32'd0);
    tick(); chk("bltz_nt_pc", bus.pc_f_o, 32'h3018);
    op(3'd6, 32'h0000_0C10, 32'h3010, 32'd0, 32'd0);
    tick(); chk("j_pc", bus.pc_f_o, 32'h3040);

    // jr alignment and window checks.
    op(3'd7, 32'h0, 32'h3040, 32'h3002, 32'd0);
    tick(); chk("jr_mis_pc", bus.pc_f_o, 32'h3002); chk("jr_mis_adel", 32'(bus.adel_f_o), 32'd1);
    op(3'd7, 32'h0, 32'h3040, 32'h8000, 32'd0);
    tick(); chk("jr_oow_adel", 32'(bus.adel_f_o), 32'd1);
    op(3'd7, 32'h0, 32'h3040, 32'h3100, 32'd0);
    tick(); chk("jr_ok_adel", 32'(bus.adel_f_o), 32'd0);

    // Wrap-around of the sequential PC.
    op(3'd7, 32'h0, 32'h3040, 32'hFFFF_FFFC, 32'd0);
    tick(); chk("wrap_top", bus.pc_f_o, 32'hFFFF_FFFC);
    idle();
    tick(); chk("wrap_pc", bus.pc_f_o, 32'h0); chk("wrap_adel", 32'(bus.adel_f_o), 32'd1);

    // Taken beq held by two stall cycles redirects exactly once.
    op(3'd7, 32'h0, 32'h3040, 32'h3200, 32'd0);
    tick();
    op(3'd1, 32'h0000_0008, 32'h3100, 32'd3, 32'd3);
    bus.stall_i = 1'b1;
    tick(); chk("stall1_pc", bus.pc_f_o, 32'h3200);
    tick(); chk("stall2_pc", bus.pc_f_o, 32'h3200);
    bus.stall_i = 1'b0;
    tick(); chk("stall_redirect", bus.pc_f_o, 32'h3124);
    idle();
    tick(); chk("stall_once", bus.pc_f_o, 32'h3128);

    // Exception beats stall and eret; eret; reset beats exception.
    op(3'd6, 32'h0000_0C10, 32'h3010, 32'd0, 32'd0);
    bus.stall_i = 1'b1; bus.exc_req_i = 1'b1; bus.eret_req_i = 1'b1; bus.epc_i = 32'h3020;
    tick(); chk("exc_pc", bus.pc_f_o, 32'h4180); chk("exc_bd", 32'(bus.bd_f_o), 32'd0);
    idle(); bus.eret_req_i = 1'b1; bus.epc_i = 32'h3020;
    tick(); chk("eret_pc", bus.pc_f_o, 32'h3020);
    idle(); bus.exc_req_i = 1'b1; reset = 1'b0;
    tick(); chk("rst_exc_pc", bus.pc_f_o, 32'h3000);
    reset = 1'b1;

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset          = ($urandom_range(0, 199) != 0);
      bus.stall_i    = ($urandom_range(0, 3) == 0);
      bus.br_sel_i   = 3'($urandom_range(0, 7));
      bus.instr_d_i  = $urandom;
      bus.pc_d_i     = 32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
      case ($urandom_range(0, 3))
        0: begin bus.rs_val_i = $urandom; bus.rt_val_i = bus.rs_val_i; end
        1: begin bus.rs_val_i = 32'h3000 + $urandom_range(0, 32'h4010); bus.rt_val_i = $urandom; end
        2: begin bus.rs_val_i = 32'($urandom_range(0, 2)) - 32'd1; bus.rt_val_i = $urandom; end
        default: begin bus.rs_val_i = $urandom; bus.rt_val_i = $urandom; end
      endcase
      bus.exc_req_i  = ($urandom_range(0, 29) == 0);
      bus.eret_req_i = ($urandom_range(0, 29) == 0);
      bus.epc_i      = ($urandom_range(0, 1) == 0) ? 32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC)
                                                   : $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
